// File: rtl/sequencer_dbg_avl_arbiter_if.sv
// sequencer_dbg_avl_arbiter_if: one Avalon-MM port bundle (command, write data, read data, stall)
interface sequencer_dbg_avl_arbiter_if #(
  parameter int AVL_DATA_WIDTH = 32,
  parameter int AVL_ADDR_WIDTH = 16
);
  logic [AVL_ADDR_WIDTH-1:0] address;
  logic                      write;
  logic [AVL_DATA_WIDTH-1:0] writedata;
  logic                      read;
  logic [AVL_DATA_WIDTH-1:0] readdata;
  logic                      waitrequest;
  modport master (output address, write, writedata, read, input readdata, waitrequest);
  modport slave (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/sequencer_dbg_avl_arbiter.sv
// sequencer_dbg_avl_arbiter: round-robin 2:1 Avalon-MM arbiter (NIOS + JTAG) in front of the pointer-manager regfile; SEQ_DBG_ARB_TIMEOUT_EN adds an ISSUE-state abort timer and sticky arb_timeout
module sequencer_dbg_avl_arbiter #(
  parameter int AVL_DATA_WIDTH = 32,
  parameter int AVL_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              avl_clk,
  input  logic                              avl_reset_n,
  sequencer_dbg_avl_arbiter_if.slave        m0,
  sequencer_dbg_avl_arbiter_if.slave        m1,
  sequencer_dbg_avl_arbiter_if.master       s,
  output logic                              grant_id,
  output logic                              arb_busy
`ifdef SEQ_DBG_ARB_TIMEOUT_EN
  ,
  output logic                              arb_timeout
`endif
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  logic [1:0]                r_state;
  logic                      r_last, r_gid, r_rd, r_wr;
  logic [AVL_ADDR_WIDTH-1:0] r_addr;
  logic [AVL_DATA_WIDTH-1:0] r_wdata, r_rdata0, r_rdata1;
  logic                      w_req0, w_req1, w_gnt, w_done, w_abort, w_cap;
  logic [AVL_DATA_WIDTH-1:0] w_rdata;
  assign w_req0  = m0.read | m0.write;
  assign w_req1  = m1.read | m1.write;
  // On a tie the master that did not win last time gets the slave
  assign w_gnt   = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_done  = (r_state == ST_ISSUE) & ~s.waitrequest;
  assign w_cap   = w_abort | (w_done & r_rd);
`ifdef SEQ_DBG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AVL_DATA_WIDTH-1:0] ABORT_DATA = AVL_DATA_WIDTH'(32'hDEAD_BEEF);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  assign w_abort     = (r_state == ST_ISSUE) & s.waitrequest & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_rdata     = w_abort ? ABORT_DATA : s.readdata;
  assign arb_timeout = r_timeout;
  // Count ISSUE cycles; held at zero elsewhere so each ISSUE starts from zero
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) r_cnt <= '0;
    else r_cnt <= (r_state == ST_ISSUE) ? r_cnt + 1'b1 : '0;
  end
  // Sticky abort flag, only reset clears it
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) r_timeout <= 1'b0;
    else if (w_abort) r_timeout <= 1'b1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_abort = 1'b0;
  assign w_rdata = s.readdata;
`endif
  // Arbitration FSM: latch the winner's command, hold it through ISSUE, one RESP cycle
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_gid   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req0 | w_req1) begin
          r_state <= ST_ISSUE;
          r_gid   <= w_gnt;
          r_last  <= w_gnt;
          r_addr  <= w_gnt ? m1.address : m0.address;
          r_wdata <= w_gnt ? m1.writedata : m0.writedata;
          r_wr    <= w_gnt ? m1.write : m0.write;
          r_rd    <= w_gnt ? (m1.read & ~m1.write) : (m0.read & ~m0.write);
        end
        ST_ISSUE: if (w_done | w_abort) begin
          r_state <= ST_RESP;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  // Per-master read data, updated only by a completed read or an abort
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_cap) begin
      if (r_gid) r_rdata1 <= w_rdata;
      else r_rdata0 <= w_rdata;
    end
  end
  assign s.address      = r_addr;
  assign s.writedata    = r_wdata;
  assign s.read         = r_rd;
  assign s.write        = r_wr;
  assign m0.readdata    = r_rdata0;
  assign m1.readdata    = r_rdata1;
  assign m0.waitrequest = ~((r_state == ST_RESP) & ~r_gid);
  assign m1.waitrequest = ~((r_state == ST_RESP) & r_gid);
  assign grant_id       = r_gid;
  assign arb_busy       = r_state != ST_IDLE;
endmodule
